// File: rtl/fan_speed_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fan_speed_ctrl_if
//  Description : Wishbone slave bus bundle for the fan speed controller.
//                The master modport drives the request side; the slave
//                modport returns registered read data and ack.
//  Revision    : 1.0  initial release
// ============================================================================
interface fan_speed_ctrl_if;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic [15:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface
`default_nettype wire

// File: rtl/fan_speed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fan_speed_ctrl
//  Description : Closed-loop fan controller. Per-fan 8-bit PWM, tachometer
//                edge counting per measurement window with stall flags, and
//                temperature snooping from the ADC stream. AUTO mode raises
//                duty from temperature thresholds and forces full speed when
//                the temperature is stale or the thresholds are inverted.
//  Revision    : 1.0  initial release
// ============================================================================
module fan_speed_ctrl #(
   parameter int         NUM_FANS     = 3,
   parameter int         PWM_PRESCALE = 16,
   parameter int         TACH_WINDOW  = 1000000,
   parameter logic [4:0] TEMP_CHANNEL = 5'd0,
   parameter int         TEMP_TIMEOUT = 2000000
) (
   input  wire                  wb_clk_i,
   input  wire                  wb_rst_i,
   fan_speed_ctrl_if.slave      wb,
   input  wire  [11:0]          adc_result,
   input  wire  [4:0]           adc_channel,
   input  wire                  adc_strb,
   input  wire  [NUM_FANS-1:0]  fan_sense,
   output logic [NUM_FANS-1:0]  fan_control
);

   localparam int c_PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
   localparam int c_WIN_W = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
   localparam int c_TMO_W = $clog2(TEMP_TIMEOUT + 1);

   // Bus side
   logic        r_ack;
   logic [15:0] r_dat;
   logic        w_wb_req;
   logic        w_wb_wr;
   logic [3:0]  w_addr;
   logic [15:0] w_rd_data;
   logic        w_unused_bits;

   // Configuration and temperature
   logic               r_mode;
   logic [11:0]        r_temp_lo;
   logic [11:0]        r_temp_hi;
   logic [11:0]        r_temp;
   logic               r_temp_valid;
   logic [c_TMO_W-1:0] r_tmo_cnt;
   logic [7:0]         r_duty     [NUM_FANS];
   logic [7:0]         w_eff      [NUM_FANS];
   logic               w_temp_hit;

   // PWM
   logic [c_PRE_W-1:0] r_pre_cnt;
   logic [7:0]         r_phase;
   logic [7:0]         r_duty_act [NUM_FANS];
   logic               w_tick;

   // Tachometer
   logic [NUM_FANS-1:0] r_sync1;
   logic [NUM_FANS-1:0] r_sync2;
   logic [NUM_FANS-1:0] r_sense_d;
   logic [NUM_FANS-1:0] w_edge;
   logic [c_WIN_W-1:0]  r_win_cnt;
   logic                w_win_tc;
   logic [15:0]         r_edge_cnt [NUM_FANS];
   logic [15:0]         r_tach     [NUM_FANS];
   logic [NUM_FANS-1:0] r_stall;

   assign w_wb_req      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
   assign w_wb_wr       = w_wb_req & wb.wb_we_i;
   assign w_addr        = wb.wb_adr_i[3:0];
   assign wb.wb_ack_o   = r_ack;
   assign wb.wb_dat_o   = r_dat;
   assign w_unused_bits = ^{wb.wb_adr_i[15:4], wb.wb_dat_i[15:12]};
   assign w_temp_hit    = adc_strb && (adc_channel == TEMP_CHANNEL);
   assign w_tick        = (r_pre_cnt == c_PRE_W'(PWM_PRESCALE - 1));
   assign w_win_tc      = (r_win_cnt == c_WIN_W'(TACH_WINDOW - 1));
   assign w_edge        = r_sync2 & ~r_sense_d;

   // Read data mux; anything not matched reads as zero
   always_comb begin
      w_rd_data = '0;
      case (w_addr)
         4'h0:    w_rd_data = {15'd0, r_mode};
         4'h1:    w_rd_data = {4'd0, r_temp_lo};
         4'h2:    w_rd_data = {4'd0, r_temp_hi};
         4'h3:    w_rd_data = {r_temp_valid, 3'b000, r_temp};
         4'h4:    w_rd_data[NUM_FANS-1:0] = r_stall;
         default: w_rd_data = '0;
      endcase
      for (int n = 0; n < NUM_FANS; n++) begin
         if (w_addr == 4'(8 + n))  w_rd_data = {8'd0, r_duty[n]};
         if (w_addr == 4'(12 + n)) w_rd_data = r_tach[n];
      end
   end

   // Single-cycle ack with read data captured on the same edge
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_wb_req;
         if (w_wb_req && !wb.wb_we_i) r_dat <= w_rd_data;
      end
   end

   // Writable configuration registers; RO and unmapped writes fall through
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_mode    <= 1'b0;
         r_temp_lo <= 12'h800;
         r_temp_hi <= 12'hC00;
         for (int n = 0; n < NUM_FANS; n++) r_duty[n] <= 8'hFF;
      end else if (w_wb_wr) begin
         if (w_addr == 4'h0) r_mode    <= wb.wb_dat_i[0];
         if (w_addr == 4'h1) r_temp_lo <= wb.wb_dat_i[11:0];
         if (w_addr == 4'h2) r_temp_hi <= wb.wb_dat_i[11:0];
         for (int n = 0; n < NUM_FANS; n++) begin
            if (w_addr == 4'(8 + n)) r_duty[n] <= wb.wb_dat_i[7:0];
         end
      end
   end

   // Temperature snoop with staleness timeout; a fresh sample beats expiry
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_temp       <= '0;
         r_temp_valid <= 1'b0;
         r_tmo_cnt    <= '0;
      end else if (w_temp_hit) begin
         r_temp       <= adc_result;
         r_temp_valid <= 1'b1;
         r_tmo_cnt    <= '0;
      end else if (r_tmo_cnt == c_TMO_W'(TEMP_TIMEOUT)) begin
         r_temp_valid <= 1'b0;
      end else begin
         r_tmo_cnt    <= r_tmo_cnt + 1'b1;
      end
   end

   // Effective duty: manual value, or temperature-driven floor in AUTO
   always_comb begin
      for (int n = 0; n < NUM_FANS; n++) begin
         w_eff[n] = r_duty[n];
         if (r_mode) begin
            if (!r_temp_valid || (r_temp_lo >= r_temp_hi) || (r_temp >= r_temp_hi))
               w_eff[n] = 8'hFF;
            else if (r_temp > r_temp_lo)
               w_eff[n] = (r_duty[n] < 8'd192) ? 8'd192 : r_duty[n];
         end
      end
   end

   // PWM timebase; active duty only reloads when the phase wraps to zero
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_pre_cnt <= '0;
         r_phase   <= '0;
         for (int n = 0; n < NUM_FANS; n++) r_duty_act[n] <= 8'hFF;
      end else if (w_tick) begin
         r_pre_cnt <= '0;
         r_phase   <= r_phase + 8'd1;
         if (r_phase == 8'hFF) begin
            for (int n = 0; n < NUM_FANS; n++) r_duty_act[n] <= w_eff[n];
         end
      end else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
      end
   end

   // Registered PWM outputs; 0 and 255 are held constant
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         fan_control <= '1;
      end else begin
         for (int n = 0; n < NUM_FANS; n++) begin
            if (r_duty_act[n] == 8'hFF)      fan_control[n] <= 1'b1;
            else if (r_duty_act[n] == 8'h00) fan_control[n] <= 1'b0;
            else                             fan_control[n] <= (r_phase < r_duty_act[n]);
         end
      end
   end

   // Tach input synchroniser and edge-detect history
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_sense_d <= '0;
      end else begin
         r_sync1   <= fan_sense;
         r_sync2   <= r_sync1;
         r_sense_d <= r_sync2;
      end
   end

   // Window counting, per-fan edge counts, capture and stall evaluation
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_win_cnt <= '0;
         r_stall   <= '0;
         for (int n = 0; n < NUM_FANS; n++) begin
            r_edge_cnt[n] <= '0;
            r_tach[n]     <= '0;
         end
      end else begin
         r_win_cnt <= w_win_tc ? '0 : r_win_cnt + 1'b1;
         for (int n = 0; n < NUM_FANS; n++) begin
            if (w_win_tc) begin
               r_tach[n]     <= r_edge_cnt[n];
               r_edge_cnt[n] <= {15'd0, w_edge[n]};
               r_stall[n]    <= (r_edge_cnt[n] == 16'd0) && (r_duty_act[n] != 8'd0);
            end else if (w_edge[n] && (r_edge_cnt[n] != 16'hFFFF)) begin
               r_edge_cnt[n] <= r_edge_cnt[n] + 16'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fan_speed_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fan_speed_ctrl
//  Description : Self-checking bench for fan_speed_ctrl. Bus reads are
//                scoreboarded against a behavioural register/duty model;
//                PWM high time and tach counts are derived from the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fan_speed_ctrl;

   localparam int NF = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [11:0]   adc_result;
   logic [4:0]    adc_channel;
   logic          adc_strb;
   logic [NF-1:0] fan_sense;
   logic [NF-1:0] fan_control;

   fan_speed_ctrl_if bus ();

   fan_speed_ctrl #(
      .NUM_FANS     (NF),
      .PWM_PRESCALE (1),
      .TACH_WINDOW  (1000),
      .TEMP_CHANNEL (5'd0),
      .TEMP_TIMEOUT (5000)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wb          (bus.slave),
      .adc_result  (adc_result),
      .adc_channel (adc_channel),
      .adc_strb    (adc_strb),
      .fan_sense   (fan_sense),
      .fan_control (fan_control)
   );

   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   int m_mode, m_lo, m_hi, m_temp, m_valid;
   int m_duty [NF];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        is_rd;
      logic [3:0]  adr;
      logic [15:0] exp;
   } exp_t;
   exp_t sb_q [$];

   int half_p [NF];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic void model_reset();
      m_mode = 0; m_lo = 'h800; m_hi = 'hC00; m_temp = 0; m_valid = 0;
      for (int n = 0; n < NF; n++) m_duty[n] = 255;
   endfunction

   function automatic void model_write(input int adr, input int data);
      case (adr)
         0:       m_mode = data & 1;
         1:       m_lo   = data & 'hFFF;
         2:       m_hi   = data & 'hFFF;
         8, 9, 10: m_duty[adr-8] = data & 'hFF;
         default: ;
      endcase
   endfunction

   function automatic int model_read(input int adr);
      case (adr)
         0:       return m_mode;
         1:       return m_lo;
         2:       return m_hi;
         3:       return (m_valid << 15) | m_temp;
         8, 9, 10: return m_duty[adr-8];
         default: return 0;
      endcase
   endfunction

   function automatic int model_eff(input int n);
      int d = m_duty[n];
      if (m_mode == 0) return d;
      if (m_valid == 0 || m_lo >= m_hi || m_temp >= m_hi) return 255;
      if (m_temp > m_lo) return (d > 192) ? d : 192;
      return d;
   endfunction

   // ---------------- bus master ----------------
   task automatic wb_xfer(input logic we, input int adr, input int data, input int exp);
      exp_t e;
      int   lat;
      e.is_rd = !we;
      e.adr   = 4'(adr);
      e.exp   = 16'(exp);
      sb_q.push_back(e);
      @(negedge clk);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = 16'(adr);
      bus.wb_dat_i = 16'(data);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.wb_ack_o !== 1'b1 && lat < 8);
      check($sformatf("ack_latency_0x%0h", adr), lat, 1);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      @(negedge clk);
      check($sformatf("ack_single_0x%0h", adr), int'(bus.wb_ack_o), 0);
   endtask

   task automatic wb_write(input int adr, input int data);
      model_write(adr, data);
      wb_xfer(1'b1, adr, data, 0);
   endtask

   task automatic wb_read(input int adr, input int exp);
      wb_xfer(1'b0, adr, 0, exp);
   endtask

   task automatic wb_read_model(input int adr);
      wb_xfer(1'b0, adr, 0, model_read(adr));
   endtask

   // Scoreboard monitor: pops one entry per ack, compares read data
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (bus.wb_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard");
            end else begin
               e = sb_q.pop_front();
               if (e.is_rd)
                  check($sformatf("read_0x%0h", e.adr), int'(bus.wb_dat_o), int'(e.exp));
            end
         end
      end
   end

   // Tach stimulus: fan n toggles every half_p[n] cycles, static when 0
   initial begin
      int cnt [NF];
      fan_sense = '0;
      for (int n = 0; n < NF; n++) begin cnt[n] = 0; half_p[n] = 0; end
      forever begin
         @(negedge clk);
         for (int n = 0; n < NF; n++) begin
            cnt[n]++;
            if (half_p[n] > 0 && cnt[n] >= half_p[n]) begin
               fan_sense[n] = ~fan_sense[n];
               cnt[n] = 0;
            end
         end
      end
   end

   task automatic adc_sample(input int ch, input int val);
      @(negedge clk);
      adc_channel = 5'(ch);
      adc_result  = 12'(val);
      adc_strb    = 1'b1;
      @(negedge clk);
      adc_strb    = 1'b0;
      if (ch == 0) begin m_temp = val; m_valid = 1; end
   endtask

   task automatic measure(input int n, input int ncyc, output int highs);
      highs = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (fan_control[n]) highs++;
      end
   endtask

   task automatic check_duty(input string name, input int n);
      int h, e;
      e = model_eff(n);
      measure(n, 256, h);
      check(name, h, (e == 255) ? 256 : e);
   endtask

   task automatic wait_rise(input int n);
      logic prev;
      int   k;
      int   found;
      prev  = fan_control[n];
      found = 0;
      k     = 0;
      while (found == 0 && k < 600) begin
         @(negedge clk);
         k++;
         if (!prev && fan_control[n]) found = 1;
         prev = fan_control[n];
      end
      check("pwm_rise_seen", found, 1);
   endtask

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int h, d, lo, hi, t, p0, p2;
      int halves [5] = '{5, 10, 20, 25, 50};
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
      adc_result = '0; adc_channel = '0; adc_strb = 1'b0;
      model_reset();
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("fan_ctrl_in_reset", int'(fan_control), 7);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("fan_ctrl_after_reset", int'(fan_control), 7);

      // 1: reset values
      wb_read_model(8);
      wb_read_model(0);
      wb_read_model(1);
      wb_read_model(2);
      wb_read_model(3);
      wb_read(4, 0);
      wb_read(12, 0);

      // 2: manual duties
      wb_write(8, 'h40);
      wb_write(9, 'h00);
      wb_write(10, 'hFF);
      repeat (320) @(negedge clk);
      check_duty("pwm_fan0_0x40", 0);
      check_duty("pwm_fan1_0x00", 1);
      check_duty("pwm_fan2_0xFF", 2);

      // 3: tach and stall
      half_p[0] = 10;
      wb_write(9, 'h80);
      repeat (2500) @(negedge clk);
      wb_read(12, 50);
      wb_read(13, 0);
      wb_read(4, 'b110);
      wb_write(9, 'h00);
      repeat (1500) @(negedge clk);
      wb_read(4, 'b100);

      for (int i = 0; i < 3; i++) begin
         p0 = halves[$urandom_range(0, 4)];
         p2 = halves[$urandom_range(0, 4)];
         half_p[0] = p0;
         half_p[2] = p2;
         repeat (2500) @(negedge clk);
         wb_read(12, 1000 / (2 * p0));
         wb_read(14, 1000 / (2 * p2));
      end
      half_p[0] = 0;
      half_p[2] = 0;

      // 4: AUTO thresholds
      wb_write(0, 1);
      wb_write(8, 'h40);
      adc_sample(0, 'h700);
      repeat (320) @(negedge clk);
      check_duty("auto_below_lo", 0);
      adc_sample(0, 'h900);
      repeat (320) @(negedge clk);
      check_duty("auto_mid", 0);
      check_duty("auto_mid_fan1", 1);
      adc_sample(0, 'hC00);
      repeat (320) @(negedge clk);
      check_duty("auto_at_hi", 0);
      adc_sample(3, 'h123);
      wb_read_model(3);

      // 5: stale temperature fails safe
      adc_sample(0, 'h700);
      repeat (5100) @(negedge clk);
      m_valid = 0;
      wb_read_model(3);
      repeat (200) @(negedge clk);
      check_duty("stale_fan0", 0);
      check_duty("stale_fan1", 1);
      check_duty("stale_fan2", 2);
      adc_sample(0, 'h700);
      repeat (320) @(negedge clk);
      check_duty("restored_fan0", 0);

      // 6: mid-period write only lands at the wrap; ignored writes
      wb_write(0, 0);
      adc_sample(0, 'h345);
      wb_write(8, 'h40);
      repeat (320) @(negedge clk);
      wait_rise(0);
      repeat (100) @(negedge clk);
      wb_write(8, 'hC0);
      wb_write(15, 'h1234);
      wb_write(3, 'h5555);
      measure(0, 120, h);
      check("duty_held_until_wrap", h, 0);
      repeat (300) @(negedge clk);
      check_duty("duty_after_wrap", 0);
      wb_read_model(8);
      wb_read(15, 0);
      wb_read(11, 0);
      wb_read(5, 0);
      wb_read_model(3);

      // Randomised configuration sweep
      for (int i = 0; i < 8; i++) begin
         lo = $urandom_range(0, 'h9FF);
         hi = $urandom_range('h400, 'hFFF);
         d  = (i % 4 == 0) ? 0 : $urandom_range(0, 255);
         t  = $urandom_range(0, 'hFFF);
         wb_write(0, $urandom_range(0, 1));
         wb_write(1, lo);
         wb_write(2, hi);
         wb_write(8, d);
         wb_write(10, $urandom_range(0, 255));
         adc_sample(0, t);
         repeat (320) @(negedge clk);
         check_duty($sformatf("rand%0d_fan0", i), 0);
         check_duty($sformatf("rand%0d_fan2", i), 2);
         wb_read_model(3);
      end

      // Reset in the middle of a PWM period
      wb_write(0, 0);
      wb_write(8, 'h40);
      half_p[0] = 10;
      repeat (1300) @(negedge clk);
      h = 0;
      while (fan_control[0] && h < 300) begin @(negedge clk); h++; end
      check("fan0_low_before_reset", int'(fan_control[0]), 0);
      #3 rst = 1'b1;
      #1 check("async_reset_fan_ctrl", int'(fan_control), 7);
      model_reset();
      half_p[0] = 0;
      @(negedge clk);
      rst = 1'b0;
      wb_read(12, 0);
      wb_read(4, 0);
      wb_read_model(3);
      wb_read_model(8);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
